// File: rtl/pong_text_pkg.sv
// Shared constants, types and width helper for the pong text renderers.
package pong_text_pkg;

   localparam int GLYPH_W = 6;
   localparam int GLYPH_H = 8;
   localparam logic [6:0] ASCII_BLANK = 7'h20;

   typedef enum logic {
      IDLE,
      REVEAL
   } reveal_state_t;

   // Bits needed to index n items, never less than one.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/glyph_rom_6x8.sv
// 6x8 character cell ROM: 5x7 glyph, blank column 5 and blank row 7.
module glyph_rom_6x8
   import pong_text_pkg::*;
(
   input  logic [6:0] char_code,
   input  logic [2:0] row,
   input  logic [2:0] col,
   output logic       pixel
);

   logic [6:0]  code;
   logic [39:0] cols;
   logic [5:0]  bit_sel;

   // Five column bytes, leftmost in the MSBs, bit 0 of a byte is the top row.
   always_comb begin
      code = char_code;
      if (char_code >= 7'h61 && char_code <= 7'h7A)
         code = char_code - 7'h20;
      cols = '0;
      case (code)
         ASCII_BLANK: cols = 40'h00_00_00_00_00;
         7'h21: cols = 40'h00_00_5F_00_00;
         7'h22: cols = 40'h00_07_00_07_00;
         7'h23: cols = 40'h14_7F_14_7F_14;
         7'h24: cols = 40'h24_2A_7F_2A_12;
         7'h25: cols = 40'h23_13_08_64_62;
         7'h26: cols = 40'h36_49_55_22_50;
         7'h27: cols = 40'h00_05_03_00_00;
         7'h28: cols = 40'h00_1C_22_41_00;
         7'h29: cols = 40'h00_41_22_1C_00;
         7'h2A: cols = 40'h08_2A_1C_2A_08;
         7'h2B: cols = 40'h08_08_3E_08_08;
         7'h2C: cols = 40'h00_50_30_00_00;
         7'h2D: cols = 40'h08_08_08_08_08;
         7'h2E: cols = 40'h00_60_60_00_00;
         7'h2F: cols = 40'h20_10_08_04_02;
         7'h30: cols = 40'h3E_51_49_45_3E;
         7'h31: cols = 40'h00_42_7F_40_00;
         7'h32: cols = 40'h42_61_51_49_46;
         7'h33: cols = 40'h21_41_45_4B_31;
         7'h34: cols = 40'h18_14_12_7F_10;
         7'h35: cols = 40'h27_45_45_45_39;
         7'h36: cols = 40'h3C_4A_49_49_30;
         7'h37: cols = 40'h01_71_09_05_03;
         7'h38: cols = 40'h36_49_49_49_36;
         7'h39: cols = 40'h06_49_49_29_1E;
         7'h3A: cols = 40'h00_36_36_00_00;
         7'h3B: cols = 40'h00_56_36_00_00;
         7'h3C: cols = 40'h00_08_14_22_41;
         7'h3D: cols = 40'h14_14_14_14_14;
         7'h3E: cols = 40'h41_22_14_08_00;
         7'h3F: cols = 40'h02_01_51_09_06;
         7'h40: cols = 40'h32_49_79_41_3E;
         7'h41: cols = 40'h7E_11_11_11_7E;
         7'h42: cols = 40'h7F_49_49_49_36;
         7'h43: cols = 40'h3E_41_41_41_22;
         7'h44: cols = 40'h7F_41_41_22_1C;
         7'h45: cols = 40'h7F_49_49_49_41;
         7'h46: cols = 40'h7F_09_09_01_01;
         7'h47: cols = 40'h3E_41_41_51_32;
         7'h48: cols = 40'h7F_08_08_08_7F;
         7'h49: cols = 40'h00_41_7F_41_00;
         7'h4A: cols = 40'h20_40_41_3F_01;
         7'h4B: cols = 40'h7F_08_14_22_41;
         7'h4C: cols = 40'h7F_40_40_40_40;
         7'h4D: cols = 40'h7F_02_04_02_7F;
         7'h4E: cols = 40'h7F_04_08_10_7F;
         7'h4F: cols = 40'h3E_41_41_41_3E;
         7'h50: cols = 40'h7F_09_09_09_06;
         7'h51: cols = 40'h3E_41_51_21_5E;
         7'h52: cols = 40'h7F_09_19_29_46;
         7'h53: cols = 40'h46_49_49_49_31;
         7'h54: cols = 40'h01_01_7F_01_01;
         7'h55: cols = 40'h3F_40_40_40_3F;
         7'h56: cols = 40'h1F_20_40_20_1F;
         7'h57: cols = 40'h7F_20_18_20_7F;
         7'h58: cols = 40'h63_14_08_14_63;
         7'h59: cols = 40'h03_04_78_04_03;
         7'h5A: cols = 40'h61_51_49_45_43;
         7'h5B: cols = 40'h00_00_7F_41_41;
         7'h5C: cols = 40'h02_04_08_10_20;
         7'h5D: cols = 40'h41_41_7F_00_00;
         7'h5E: cols = 40'h04_02_01_02_04;
         7'h5F: cols = 40'h40_40_40_40_40;
         7'h60: cols = 40'h00_01_02_04_00;
         7'h7B: cols = 40'h00_08_36_41_00;
         7'h7C: cols = 40'h00_00_7F_00_00;
         7'h7D: cols = 40'h00_41_36_08_00;
         7'h7E: cols = 40'h08_04_08_10_08;
         default: cols = '0;
      endcase
      bit_sel = {3'd4 - col, row};
      pixel = (col < 3'd5) && cols[bit_sel];
   end

endmodule

// File: rtl/dyn_string_display.sv
// Runtime-writable text overlay with typewriter reveal, 2-cycle pixel path.
// Optional blink gating is built when DYN_STRING_BLINK_EN is defined.
module dyn_string_display
   import pong_text_pkg::*;
#(
   parameter int SCALE = 4,
   parameter int KERNING = 4,
   parameter int LEN = 8,
   parameter logic [LEN*8-1:0] INIT_TEXT = {LEN{8'h20}},
   parameter int REVEAL_FRAMES = 4
`ifdef DYN_STRING_BLINK_EN
   , parameter int BLINK_FRAMES = 30
`endif
) (
   input  logic                   clk_0,
   input  logic                   rst,
   input  logic [9:0]             pixel_x,
   input  logic [9:0]             pixel_y,
   input  logic [9:0]             x_pos,
   input  logic [9:0]             y_pos,
   input  logic                   vblank,
   input  logic                   frame_tick,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [clog2(LEN)-1:0]  wr_idx,
   input  logic [6:0]             wr_char,
   input  logic                   reveal_start,
   output logic                   reveal_done,
`ifdef DYN_STRING_BLINK_EN
   input  logic                   blink,
`endif
   output logic                   pixel_on
);

   localparam int PITCH  = GLYPH_W * SCALE + KERNING;
   localparam int SPAN   = LEN * PITCH - KERNING;
   localparam int HEIGHT = GLYPH_H * SCALE;
   localparam int CNT_W  = clog2(LEN + 1);
   localparam int DIV_W  = clog2(REVEAL_FRAMES);
   localparam logic [10:0] PITCH_W = 11'(PITCH);
   localparam logic [10:0] SCALE_W = 11'(SCALE);

   logic [6:0]       text_q [LEN];
   reveal_state_t    state_q, state_n;
   logic [CNT_W-1:0] count_q, count_n;
   logic [DIV_W-1:0] div_q, div_n;

   logic [10:0] rx, ry, idx_full, col_full, row_full;
   logic        lit_d;
   logic [6:0]  char_d;
   logic        v1_q;
   logic [6:0]  char_q;
   logic [2:0]  row_q, col_q;
   logic        rom_px, blank_px;

   assign wr_ready = vblank & ~rst;

   // Out-of-range slots match no entry, so their data is dropped.
   always_ff @(posedge clk_0 or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LEN; i++)
            text_q[i] <= INIT_TEXT[8*(LEN-1-i) +: 7];
      end else if (wr_valid && wr_ready) begin
         for (int i = 0; i < LEN; i++)
            if (int'(wr_idx) == i) text_q[i] <= wr_char;
      end
   end

   always_ff @(posedge clk_0 or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= CNT_W'(LEN);
         div_q   <= '0;
      end else begin
         state_q <= state_n;
         count_q <= count_n;
         div_q   <= div_n;
      end
   end

   always_comb begin
      state_n = state_q;
      count_n = count_q;
      div_n   = div_q;
      unique case (state_q)
         IDLE: state_n = IDLE;
         REVEAL: begin
            if (frame_tick) begin
               if (int'(div_q) == REVEAL_FRAMES - 1) begin
                  div_n   = '0;
                  count_n = count_q + 1'b1;
                  if (int'(count_q) == LEN - 1) state_n = IDLE;
               end else begin
                  div_n = div_q + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      // A restart overrides any tick landing in the same cycle.
      if (reveal_start) begin
         state_n = REVEAL;
         count_n = '0;
         div_n   = '0;
      end
   end

   assign reveal_done = (state_q == IDLE);

   // Negative offsets wrap to large values and fall outside the span.
   always_comb begin
      rx       = {1'b0, pixel_x} - {1'b0, x_pos};
      ry       = {1'b0, pixel_y} - {1'b0, y_pos};
      idx_full = rx / PITCH_W;
      col_full = (rx % PITCH_W) / SCALE_W;
      row_full = ry / SCALE_W;
      lit_d    = (int'(rx) < SPAN) && (int'(ry) < HEIGHT)
               && (int'(col_full) < GLYPH_W)
               && (int'(idx_full) < int'(count_q));
      char_d   = ASCII_BLANK;
      for (int i = 0; i < LEN; i++)
         if (int'(idx_full) == i) char_d = text_q[i];
   end

   always_ff @(posedge clk_0 or posedge rst) begin
      if (rst) begin
         v1_q   <= 1'b0;
         char_q <= ASCII_BLANK;
         row_q  <= '0;
         col_q  <= '0;
      end else begin
         v1_q   <= lit_d;
         char_q <= char_d;
         row_q  <= 3'(row_full);
         col_q  <= 3'(col_full);
      end
   end

   glyph_rom_6x8 u_rom (
      .char_code (char_q),
      .row       (row_q),
      .col       (col_q),
      .pixel     (rom_px)
   );

`ifdef DYN_STRING_BLINK_EN
   localparam int BLK_W = clog2(BLINK_FRAMES);
   logic [BLK_W-1:0] blk_cnt_q;
   logic             phase_q;

   always_ff @(posedge clk_0 or posedge rst) begin
      if (rst) begin
         blk_cnt_q <= '0;
         phase_q   <= 1'b0;
      end else if (!blink) begin
         blk_cnt_q <= '0;
         phase_q   <= 1'b0;
      end else if (frame_tick) begin
         if (int'(blk_cnt_q) == BLINK_FRAMES - 1) begin
            blk_cnt_q <= '0;
            phase_q   <= ~phase_q;
         end else begin
            blk_cnt_q <= blk_cnt_q + 1'b1;
         end
      end
   end

   assign blank_px = blink & phase_q;
`else
   assign blank_px = 1'b0;
`endif

   always_ff @(posedge clk_0 or posedge rst) begin
      if (rst) pixel_on <= 1'b0;
      else     pixel_on <= v1_q & rom_px & ~blank_px;
   end

endmodule

// File: tb/tb_dyn_string_display.sv
// Directed bench for dyn_string_display: SCALE=4, KERNING=4, LEN=4, "P1  ".
module tb_dyn_string_display;

   logic       clk_0 = 1'b0;
   logic       rst;
   logic [9:0] pixel_x, pixel_y, x_pos, y_pos;
   logic       vblank, frame_tick, wr_valid, wr_ready;
   logic [1:0] wr_idx;
   logic [6:0] wr_char;
   logic       reveal_start, reveal_done, pixel_on;
`ifdef DYN_STRING_BLINK_EN
   logic       blink;
`endif

   int n_checks = 0;
   int n_fail = 0;
   logic [6:0] txt [4];
   int xp = 100;

   dyn_string_display #(
      .SCALE(4), .KERNING(4), .LEN(4),
      .INIT_TEXT(32'h5031_2020), .REVEAL_FRAMES(4)
`ifdef DYN_STRING_BLINK_EN
      , .BLINK_FRAMES(2)
`endif
   ) dut (
      .clk_0(clk_0), .rst(rst),
      .pixel_x(pixel_x), .pixel_y(pixel_y),
      .x_pos(x_pos), .y_pos(y_pos),
      .vblank(vblank), .frame_tick(frame_tick),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_idx(wr_idx), .wr_char(wr_char),
      .reveal_start(reveal_start), .reveal_done(reveal_done),
`ifdef DYN_STRING_BLINK_EN
      .blink(blink),
`endif
      .pixel_on(pixel_on)
   );

   always #5 clk_0 = ~clk_0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Hand-drawn rows 0 and 1 of the glyphs used here, column 0 in the MSB.
   function automatic logic [5:0] glyph_row(input logic [6:0] ch, input int r);
      logic [5:0] g;
      case (ch)
         7'h50:   g = (r == 0) ? 6'b111100 : 6'b100010;
         7'h31:   g = (r == 0) ? 6'b001000 : 6'b011000;
         7'h33:   g = (r == 0) ? 6'b111110 : 6'b000100;
         default: g = 6'b000000;
      endcase
      return g;
   endfunction

   function automatic logic exp_px(input int px, input int py, input int cnt);
      int rx, ry, s, c;
      logic [5:0] g;
      rx = px - xp;
      ry = py - 50;
      if (rx < 0 || rx >= 108 || ry < 0 || ry >= 32) return 1'b0;
      s = rx / 28;
      c = (rx % 28) / 4;
      if (c >= 6 || s >= cnt) return 1'b0;
      g = glyph_row(txt[s], ry / 4);
      return g[5 - c];
   endfunction

   // New pixel every cycle; each output is checked two edges after its input.
   task automatic sweep(input string tag, input int py, input int x0,
                        input int x1, input int cnt);
      pixel_y = 10'(py);
      for (int x = x0; x <= x1 + 1; x++) begin
         pixel_x = 10'(x);
         @(posedge clk_0); #1;
         if (x > x0)
            check(tag, {31'b0, pixel_on}, {31'b0, exp_px(x - 1, py, cnt)});
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         @(posedge clk_0); #1;
         frame_tick = 1'b0;
         @(posedge clk_0); #1;
      end
   endtask

   task automatic write(input logic [1:0] idx, input logic [6:0] ch);
      vblank   = 1'b1;
      wr_valid = 1'b1;
      wr_idx   = idx;
      wr_char  = ch;
      #1;
      check("wr_ready_open", {31'b0, wr_ready}, 32'd1);
      @(posedge clk_0); #1;
      wr_valid = 1'b0;
      vblank   = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      pixel_x = '0; pixel_y = '0;
      x_pos = 10'd100; y_pos = 10'd50;
      vblank = 1'b1; frame_tick = 1'b0;
      wr_valid = 1'b0; wr_idx = '0; wr_char = '0;
      reveal_start = 1'b0;
`ifdef DYN_STRING_BLINK_EN
      blink = 1'b0;
`endif
      txt = '{7'h50, 7'h31, 7'h20, 7'h20};

      repeat (2) @(posedge clk_0);
      #1;
      check("rst_pixel_on", {31'b0, pixel_on}, 32'd0);
      check("rst_reveal_done", {31'b0, reveal_done}, 32'd1);
      check("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check("wr_ready_vblank", {31'b0, wr_ready}, 32'd1);
      vblank = 1'b0;
      #1;
      check("wr_ready_active", {31'b0, wr_ready}, 32'd0);
      @(posedge clk_0); #1;

      sweep("row1_init", 54, 96, 212, 4);

      x_pos = 10'd5; xp = 5;
      sweep("wrap_left", 54, 0, 4, 4);
      x_pos = 10'd100; xp = 100;
      sweep("above_top", 49, 100, 124, 4);

      wr_valid = 1'b1; wr_idx = 2'd2; wr_char = 7'h33;
      #1;
      check("wr_ready_gated", {31'b0, wr_ready}, 32'd0);
      @(posedge clk_0); #1;
      wr_valid = 1'b0;
      sweep("gated_unchanged", 50, 150, 185, 4);

      write(2'd2, 7'h33);
      txt[2] = 7'h33;
      sweep("slot2_row0", 50, 150, 185, 4);
      sweep("slot2_row1", 54, 150, 185, 4);

      write(2'd3, 7'h31);
      txt[3] = 7'h31;
      sweep("slot3_row1", 54, 96, 212, 4);

      reveal_start = 1'b1;
      @(posedge clk_0); #1;
      reveal_start = 1'b0;
      check("reveal_started", {31'b0, reveal_done}, 32'd0);
      sweep("reveal_cnt0", 54, 96, 140, 0);
      tick(4);
      sweep("reveal_cnt1", 54, 96, 212, 1);
      tick(11);
      check("reveal_busy15", {31'b0, reveal_done}, 32'd0);
      sweep("reveal_cnt3", 54, 150, 212, 3);
      tick(1);
      check("reveal_done16", {31'b0, reveal_done}, 32'd1);
      sweep("reveal_all", 54, 96, 212, 4);

      reveal_start = 1'b1;
      @(posedge clk_0); #1;
      reveal_start = 1'b0;
      tick(10);
      check("restart_busy", {31'b0, reveal_done}, 32'd0);
      sweep("restart_cnt2", 54, 96, 212, 2);
      reveal_start = 1'b1;
      frame_tick = 1'b1;
      @(posedge clk_0); #1;
      reveal_start = 1'b0;
      frame_tick = 1'b0;
      check("start_wins_done", {31'b0, reveal_done}, 32'd0);
      sweep("start_wins_cnt0", 54, 96, 212, 0);
      tick(3);
      sweep("start_wins_3t", 54, 96, 140, 0);
      tick(1);
      sweep("start_wins_4t", 54, 96, 140, 1);
      tick(12);
      check("rerun_done", {31'b0, reveal_done}, 32'd1);

`ifdef DYN_STRING_BLINK_EN
      pixel_x = 10'd100; pixel_y = 10'd54;
      blink = 1'b1;
      repeat (3) @(posedge clk_0);
      #1;
      check("blink_ph0", {31'b0, pixel_on}, 32'd1);
      tick(1);
      check("blink_t1_on", {31'b0, pixel_on}, 32'd1);
      tick(1);
      check("blink_t2_off", {31'b0, pixel_on}, 32'd0);
      tick(1);
      check("blink_t3_off", {31'b0, pixel_on}, 32'd0);
      tick(1);
      check("blink_t4_on", {31'b0, pixel_on}, 32'd1);
      tick(2);
      check("blink_t6_off", {31'b0, pixel_on}, 32'd0);
      blink = 1'b0;
      repeat (2) @(posedge clk_0);
      #1;
      check("blink_off_on", {31'b0, pixel_on}, 32'd1);
      tick(2);
      check("blink_off_steady", {31'b0, pixel_on}, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
